// File: rtl/router_fsm_if.sv
// Handshake bundle between the router input path and its packet-sequencing FSM.
// The slave modport is the FSM itself; master is the driving side (register/synchronizer or bench).
interface router_fsm_if;
   logic       pkt_valid;
   logic [1:0] data_in;
   logic       fifo_full;
   logic       fifo_empty_0;
   logic       fifo_empty_1;
   logic       fifo_empty_2;
   logic       soft_reset_0;
   logic       soft_reset_1;
   logic       soft_reset_2;
   logic       parity_done;
   logic       low_pkt_valid;
   logic       write_enb_reg;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       rst_int_reg;
   logic       busy;

   modport slave (
      input  pkt_valid, data_in, fifo_full,
      input  fifo_empty_0, fifo_empty_1, fifo_empty_2,
      input  soft_reset_0, soft_reset_1, soft_reset_2,
      input  parity_done, low_pkt_valid,
      output write_enb_reg, detect_add, lfd_state, ld_state,
      output laf_state, full_state, rst_int_reg, busy
   );

   modport master (
      output pkt_valid, data_in, fifo_full,
      output fifo_empty_0, fifo_empty_1, fifo_empty_2,
      output soft_reset_0, soft_reset_1, soft_reset_2,
      output parity_done, low_pkt_valid,
      input  write_enb_reg, detect_add, lfd_state, ld_state,
      input  laf_state, full_state, rst_int_reg, busy
   );
endinterface

// File: rtl/router_fsm.sv
// Packet-sequencing controller for the router1x3 input path: header decode,
// payload/parity phases, full-FIFO stall and per-destination soft-reset abort.
module router_fsm (
   input  logic         clk,
   input  logic         resetn,
   router_fsm_if.slave  bus
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      WAIT_TILL_EMPTY    = 3'd1,
      LOAD_FIRST_DATA    = 3'd2,
      LOAD_DATA          = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] addr_q, addr_d;
   logic [1:0] addr_sel_s;
   logic       empty_sel_s;
   logic       soft_sel_s;

   logic detect_add_q, detect_add_d;
   logic lfd_state_q, lfd_state_d;
   logic ld_state_q, ld_state_d;
   logic laf_state_q, laf_state_d;
   logic full_state_q, full_state_d;
   logic rst_int_reg_q, rst_int_reg_d;
   logic write_enb_reg_q, write_enb_reg_d;
   logic busy_q, busy_d;

   // While decoding, the live header bits pick the destination; afterwards the latched address does.
   always_comb begin
      empty_sel_s = 1'b0;
      soft_sel_s  = 1'b0;
      if (state_q == DECODE_ADDRESS) begin
         addr_sel_s = bus.data_in;
      end else begin
         addr_sel_s = addr_q;
      end
      case (addr_sel_s)
         2'd0: begin empty_sel_s = bus.fifo_empty_0; soft_sel_s = bus.soft_reset_0; end
         2'd1: begin empty_sel_s = bus.fifo_empty_1; soft_sel_s = bus.soft_reset_1; end
         2'd2: begin empty_sel_s = bus.fifo_empty_2; soft_sel_s = bus.soft_reset_2; end
         default: begin empty_sel_s = 1'b0; soft_sel_s = 1'b0; end
      endcase
   end

   // Next-state and address capture; a selected soft reset aborts any packet in flight.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      if ((state_q != DECODE_ADDRESS) && soft_sel_s) begin
         state_d = DECODE_ADDRESS;
      end else begin
         case (state_q)
            DECODE_ADDRESS: begin
               if (bus.pkt_valid && (bus.data_in != 2'd3)) begin
                  addr_d = bus.data_in;
                  if (empty_sel_s) begin
                     state_d = LOAD_FIRST_DATA;
                  end else begin
                     state_d = WAIT_TILL_EMPTY;
                  end
               end else begin
                  state_d = DECODE_ADDRESS;
               end
            end
            WAIT_TILL_EMPTY: begin
               if (empty_sel_s) state_d = LOAD_FIRST_DATA;
               else             state_d = WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
               if (bus.fifo_full)       state_d = FIFO_FULL_STATE;
               else if (!bus.pkt_valid) state_d = LOAD_PARITY;
               else                     state_d = LOAD_DATA;
            end
            FIFO_FULL_STATE: begin
               if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
               else                state_d = FIFO_FULL_STATE;
            end
            LOAD_AFTER_FULL: begin
               if (bus.parity_done)        state_d = DECODE_ADDRESS;
               else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
               else                        state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
               if (bus.fifo_full) state_d = FIFO_FULL_STATE;
               else               state_d = DECODE_ADDRESS;
            end
            default: state_d = DECODE_ADDRESS;
         endcase
      end
   end

   // Outputs are decoded from the next state and registered, so they track the state flop exactly.
   always_comb begin
      detect_add_d    = (state_d == DECODE_ADDRESS);
      lfd_state_d     = (state_d == LOAD_FIRST_DATA);
      ld_state_d      = (state_d == LOAD_DATA);
      laf_state_d     = (state_d == LOAD_AFTER_FULL);
      full_state_d    = (state_d == FIFO_FULL_STATE);
      rst_int_reg_d   = (state_d == CHECK_PARITY_ERROR);
      write_enb_reg_d = (state_d == LOAD_DATA) || (state_d == LOAD_PARITY) ||
                        (state_d == LOAD_AFTER_FULL);
      busy_d          = !((state_d == DECODE_ADDRESS) || (state_d == LOAD_DATA));
   end

   // State, address and output registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q         <= DECODE_ADDRESS;
         addr_q          <= 2'd0;
         detect_add_q    <= 1'b1;
         lfd_state_q     <= 1'b0;
         ld_state_q      <= 1'b0;
         laf_state_q     <= 1'b0;
         full_state_q    <= 1'b0;
         rst_int_reg_q   <= 1'b0;
         write_enb_reg_q <= 1'b0;
         busy_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         detect_add_q    <= detect_add_d;
         lfd_state_q     <= lfd_state_d;
         ld_state_q      <= ld_state_d;
         laf_state_q     <= laf_state_d;
         full_state_q    <= full_state_d;
         rst_int_reg_q   <= rst_int_reg_d;
         write_enb_reg_q <= write_enb_reg_d;
         busy_q          <= busy_d;
      end
   end

   assign bus.detect_add    = detect_add_q;
   assign bus.lfd_state     = lfd_state_q;
   assign bus.ld_state      = ld_state_q;
   assign bus.laf_state     = laf_state_q;
   assign bus.full_state    = full_state_q;
   assign bus.rst_int_reg   = rst_int_reg_q;
   assign bus.write_enb_reg = write_enb_reg_q;
   assign bus.busy          = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a phase-level reference model.
module tb_router_fsm;

   logic clk;
   logic resetn;
   router_fsm_if bus();

   router_fsm dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   localparam int P_DEC  = 0;
   localparam int P_WAIT = 1;
   localparam int P_LFD  = 2;
   localparam int P_LD   = 3;
   localparam int P_FULL = 4;
   localparam int P_LAF  = 5;
   localparam int P_LP   = 6;
   localparam int P_CPE  = 7;

   int         m_phase;
   logic [1:0] m_addr;

   // Output vector order: detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy
   function automatic logic [7:0] dut_vec();
      return {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
              bus.full_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
   endfunction

   function automatic logic [7:0] model_vec(input int ph);
      logic wen;
      logic bsy;
      wen = (ph == P_LD) || (ph == P_LP) || (ph == P_LAF);
      bsy = !((ph == P_DEC) || (ph == P_LD));
      return {ph == P_DEC, ph == P_LFD, ph == P_LD, ph == P_LAF,
              ph == P_FULL, ph == P_CPE, wen, bsy};
   endfunction

   function automatic int model_next(input int ph, input logic [1:0] addr);
      logic [1:0] sel;
      logic [2:0] empties;
      logic [2:0] softs;
      logic       emp;
      logic       sft;
      sel     = (ph == P_DEC) ? bus.data_in : addr;
      empties = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
      softs   = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
      emp     = (sel < 2'd3) ? empties[sel] : 1'b0;
      sft     = (sel < 2'd3) ? softs[sel] : 1'b0;
      if (ph != P_DEC && sft) return P_DEC;
      case (ph)
         P_DEC:  return (bus.pkt_valid && bus.data_in != 2'd3) ? (emp ? P_LFD : P_WAIT) : P_DEC;
         P_WAIT: return emp ? P_LFD : P_WAIT;
         P_LFD:  return P_LD;
         P_LD:   return bus.fifo_full ? P_FULL : (!bus.pkt_valid ? P_LP : P_LD);
         P_FULL: return bus.fifo_full ? P_FULL : P_LAF;
         P_LAF:  return bus.parity_done ? P_DEC : (bus.low_pkt_valid ? P_LP : P_LD);
         P_LP:   return P_CPE;
         P_CPE:  return bus.fifo_full ? P_FULL : P_DEC;
         default: return P_DEC;
      endcase
   endfunction

   // Reference model: packet phase and latched destination.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_phase <= P_DEC;
         m_addr  <= 2'd0;
      end else begin
         m_phase <= model_next(m_phase, m_addr);
         if (m_phase == P_DEC && bus.pkt_valid && bus.data_in != 2'd3)
            m_addr <= bus.data_in;
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      check("model", dut_vec(), model_vec(m_phase));
   end

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      resetn = 1'b0;
      bus.pkt_valid = 1'b0;     bus.data_in = 2'd0;       bus.fifo_full = 1'b0;
      bus.fifo_empty_0 = 1'b1;  bus.fifo_empty_1 = 1'b1;  bus.fifo_empty_2 = 1'b1;
      bus.soft_reset_0 = 1'b0;  bus.soft_reset_1 = 1'b0;  bus.soft_reset_2 = 1'b0;
      bus.parity_done = 1'b0;   bus.low_pkt_valid = 1'b0;

      repeat (2) tick();
      check("reset", dut_vec(), 8'b1000_0000);
      resetn = 1'b1;

      // Good packet, header 8'h39: addr 1, 14 payload bytes
      bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
      tick(); check("good_lfd", dut_vec(), 8'b0100_0001);
      for (int i = 0; i < 14; i++) begin
         tick(); check("good_ld", dut_vec(), 8'b0010_0010);
         if (i == 13) bus.pkt_valid = 1'b0;
      end
      tick(); check("good_lp", dut_vec(), 8'b0000_0011);
      tick(); check("good_cpe", dut_vec(), 8'b0000_0101);
      tick(); check("good_dec", dut_vec(), 8'b1000_0000);

      // Busy destination 2
      bus.pkt_valid = 1'b1; bus.data_in = 2'd2; bus.fifo_empty_2 = 1'b0;
      tick(); check("wait", dut_vec(), 8'b0000_0001);
      bus.pkt_valid = 1'b0;
      repeat (2) begin tick(); check("wait_hold", dut_vec(), 8'b0000_0001); end
      bus.fifo_empty_2 = 1'b1;
      tick(); check("wait_lfd", dut_vec(), 8'b0100_0001);
      repeat (4) tick();
      check("wait_done", dut_vec(), 8'b1000_0000);

      // Full stall on addr 0
      bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
      tick(); check("full_lfd", dut_vec(), 8'b0100_0001);
      tick(); check("full_ld", dut_vec(), 8'b0010_0010);
      bus.fifo_full = 1'b1;
      tick(); check("full_state", dut_vec(), 8'b0000_1001);
      bus.fifo_full = 1'b0;
      tick(); check("full_laf", dut_vec(), 8'b0001_0011);
      tick(); check("full_back_ld", dut_vec(), 8'b0010_0010);
      bus.fifo_full = 1'b1;
      tick(); check("full_again", dut_vec(), 8'b0000_1001);
      #2 resetn = 1'b0;
      #1 check("async_reset", dut_vec(), 8'b1000_0000);
      bus.fifo_full = 1'b0; bus.pkt_valid = 1'b0;
      tick(); resetn = 1'b1;
      check("after_reset", dut_vec(), 8'b1000_0000);

      // Soft reset of the selected FIFO aborts; of an unselected FIFO is ignored
      bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
      tick(); tick(); check("soft_ld", dut_vec(), 8'b0010_0010);
      bus.soft_reset_1 = 1'b1;
      tick(); check("soft_abort", dut_vec(), 8'b1000_0000);
      bus.soft_reset_1 = 1'b0; bus.data_in = 2'd0;
      tick(); tick(); check("soft_ld0", dut_vec(), 8'b0010_0010);
      bus.soft_reset_1 = 1'b1;
      tick(); check("soft_ignored", dut_vec(), 8'b0010_0010);
      bus.soft_reset_1 = 1'b0; bus.pkt_valid = 1'b0;
      repeat (3) tick();
      check("soft_done", dut_vec(), 8'b1000_0000);

      // Invalid address 3 is ignored
      bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
      tick(); check("bad_addr", dut_vec(), 8'b1000_0000);
      tick(); check("bad_addr_hold", dut_vec(), 8'b1000_0000);
      bus.pkt_valid = 1'b0;
      tick();

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         bus.pkt_valid     = ($urandom_range(0, 7) != 0);
         bus.data_in       = 2'($urandom_range(0, 3));
         bus.fifo_full     = ($urandom_range(0, 11) == 0);
         bus.fifo_empty_0  = ($urandom_range(0, 5) != 0);
         bus.fifo_empty_1  = ($urandom_range(0, 5) != 0);
         bus.fifo_empty_2  = ($urandom_range(0, 5) != 0);
         bus.soft_reset_0  = ($urandom_range(0, 49) == 0);
         bus.soft_reset_1  = ($urandom_range(0, 49) == 0);
         bus.soft_reset_2  = ($urandom_range(0, 49) == 0);
         bus.parity_done   = ($urandom_range(0, 4) == 0);
         bus.low_pkt_valid = ($urandom_range(0, 3) == 0);
         resetn            = ($urandom_range(0, 199) != 0);
         tick();
      end
      resetn = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
